// File: rtl/rx_fifo_pkg.sv
// rtl/rx_fifo_pkg.sv - shared UART/ALU sizing defaults for the UART, FIFO and interface blocks
package rx_fifo_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int NB_ADDR_DEF = 4;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - first-word-fall-through circular FIFO with sticky overflow/underflow flags
module rx_fifo
   import rx_fifo_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = NB_ADDR_DEF
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_wr,
   input  logic [NB_DATA-1:0] i_wr_data,
   input  logic               i_rd,
   output logic [NB_DATA-1:0] o_rd_data,
   output logic               o_empty,
   output logic               o_full,
   output logic [NB_ADDR:0]   o_count,
   output logic               o_overflow,
   output logic               o_underflow,
   input  logic               i_clr_err
);

   localparam int DEPTH = 2 ** NB_ADDR;
   localparam int CNT_W = NB_ADDR + 1;

   logic [NB_DATA-1:0] mem_q [DEPTH];
   logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
   logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic               empty, full, do_wr, do_rd;

   assign empty = (count_q == CNT_W'(0));
   assign full  = (count_q == CNT_W'(DEPTH));

   always_comb begin
      do_rd       = i_rd && !empty;
      // A full queue still accepts a write when the same cycle frees a slot.
      do_wr       = i_wr && (!full || do_rd);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (do_wr) wr_ptr_d = wr_ptr_q + NB_ADDR'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + NB_ADDR'(1);

      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (i_clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (i_wr && full && !i_rd) overflow_d  = 1'b1;
         if (i_rd && empty)         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= i_wr_data;
   end

   assign o_rd_data   = mem_q[rd_ptr_q];
   assign o_empty     = empty;
   assign o_full      = full;
   assign o_count     = count_q;
   assign o_overflow  = overflow_q;
   assign o_underflow = underflow_q;

endmodule

// File: tb/tb_rx_fifo.sv
// tb/tb_rx_fifo.sv - self-checking bench for rx_fifo against a queue-based reference model
module tb_rx_fifo;

   logic       clk = 1'b0;
   logic       i_rst_n;
   logic       i_wr;
   logic [7:0] i_wr_data;
   logic       i_rd;
   logic       i_clr_err;
   logic [7:0] o_rd_data;
   logic       o_empty;
   logic       o_full;
   logic [4:0] o_count;
   logic       o_overflow;
   logic       o_underflow;

   int checks   = 0;
   int failures = 0;

   rx_fifo #(.NB_DATA(8), .NB_ADDR(4)) dut (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_wr        (i_wr),
      .i_wr_data   (i_wr_data),
      .i_rd        (i_rd),
      .o_rd_data   (o_rd_data),
      .o_empty     (o_empty),
      .o_full      (o_full),
      .o_count     (o_count),
      .o_overflow  (o_overflow),
      .o_underflow (o_underflow),
      .i_clr_err   (i_clr_err)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue of at most 16 words plus two sticky bits.
   logic [7:0] m_q[$];
   bit         m_ovf;
   bit         m_udf;

   always @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_q.delete();
         m_ovf = 0;
         m_udf = 0;
      end else begin
         bit popped;
         bit was_full;
         bit was_empty;
         popped    = 0;
         was_full  = (m_q.size() == 16);
         was_empty = (m_q.size() == 0);
         if (i_rd && !was_empty) begin
            void'(m_q.pop_front());
            popped = 1;
         end
         if (i_wr && (!was_full || popped)) m_q.push_back(i_wr_data);
         if (i_clr_err) begin
            m_ovf = 0;
            m_udf = 0;
         end else begin
            if (i_wr && was_full && !i_rd) m_ovf = 1;
            if (i_rd && was_empty)         m_udf = 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (i_rst_n) begin
         chk("m_count", 32'(o_count), 32'(m_q.size()));
         chk("m_empty", 32'(o_empty), 32'(m_q.size() == 0));
         chk("m_full", 32'(o_full), 32'(m_q.size() == 16));
         chk("m_overflow", 32'(o_overflow), 32'(m_ovf));
         chk("m_underflow", 32'(o_underflow), 32'(m_udf));
         if (m_q.size() != 0) chk("m_rd_data", 32'(o_rd_data), 32'(m_q[0]));
      end
   end

   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
      i_wr      = w;
      i_wr_data = d;
      i_rd      = r;
      i_clr_err = c;
      @(posedge clk);
      #1;
      i_wr      = 1'b0;
      i_rd      = 1'b0;
      i_clr_err = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [7:0] exp);
      chk(name, 32'(o_rd_data), 32'(exp));
      step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      i_rst_n   = 1'b0;
      i_wr      = 1'b0;
      i_wr_data = 8'h00;
      i_rd      = 1'b0;
      i_clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(o_count), 0);
      chk("rst_empty", 32'(o_empty), 1);
      chk("rst_full", 32'(o_full), 0);
      chk("rst_flags", 32'({o_overflow, o_underflow}), 0);
      i_rst_n = 1'b1;

      // Three writes then three pops.
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      chk("w3_count", 32'(o_count), 3);
      chk("w3_empty", 32'(o_empty), 0);
      chk("w3_head", 32'(o_rd_data), 32'h A5);
      pop_expect("pop_a5", 8'hA5);
      pop_expect("pop_11", 8'h11);
      pop_expect("pop_22", 8'h22);
      chk("w3_drained", 32'(o_empty), 1);

      // Overfill: the 17th word is dropped.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("ovf_full", 32'(o_full), 1);
      chk("ovf_flag", 32'(o_overflow), 1);
      chk("ovf_count", 32'(o_count), 16);
      for (int i = 0; i < 16; i++) pop_expect("ovf_pop", 8'(i));
      chk("ovf_drained", 32'(o_empty), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", 32'(o_overflow), 0);

      // Simultaneous write/read while full.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fwr_head", 32'(o_rd_data), 32'h00);
      step(1'b1, 8'h40, 1'b1, 1'b0);
      chk("fwr_count", 32'(o_count), 16);
      chk("fwr_noovf", 32'(o_overflow), 0);
      chk("fwr_next", 32'(o_rd_data), 32'h01);
      for (int i = 1; i < 16; i++) pop_expect("fwr_pop", 8'(i));
      pop_expect("fwr_last", 8'h40);
      chk("fwr_drained", 32'(o_empty), 1);

      // Simultaneous write/read while empty.
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      chk("ewr_count", 32'(o_count), 1);
      chk("ewr_udf", 32'(o_underflow), 1);
      chk("ewr_head", 32'(o_rd_data), 32'h5A);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ewr_clr", 32'({o_overflow, o_underflow}), 0);
      pop_expect("ewr_pop", 8'h5A);

      // 40 words streamed at steady depth 3 across several pointer wraps.
      for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
      for (int k = 3; k < 40; k++) begin
         chk("stream_head", 32'(o_rd_data), 32'(8'h80 + k - 3));
         step(1'b1, 8'(8'h80 + k), 1'b1, 1'b0);
         chk("stream_depth", 32'(o_count), 3);
      end
      for (int k = 37; k < 40; k++) pop_expect("stream_tail", 8'(8'h80 + k));
      chk("stream_flags", 32'({o_overflow, o_underflow}), 0);
      chk("stream_empty", 32'(o_empty), 1);

      // Asynchronous reset mid-cycle with data and a sticky flag present.
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      chk("pre_rst_count", 32'(o_count), 5);
      chk("pre_rst_udf", 32'(o_underflow), 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(o_count), 0);
      chk("arst_empty", 32'(o_empty), 1);
      chk("arst_full", 32'(o_full), 0);
      chk("arst_flags", 32'({o_overflow, o_underflow}), 0);
      @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      chk("post_rst_empty", 32'(o_empty), 1);
      step(1'b1, 8'h77, 1'b0, 1'b0);
      chk("post_rst_count", 32'(o_count), 1);
      chk("post_rst_head", 32'(o_rd_data), 32'h77);
      repeat (2) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, meaning the data word width.
REQ-002 SHALL have parameter NB_ADDR, default 4, meaning the address width; depth = 2**NB_ADDR (16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_wr, input, 1 bit: write request, driven by the UART Rx done pulse.
REQ-006 SHALL have port i_wr_data, input, NB_DATA: the byte to write.
REQ-007 SHALL have port i_rd, input, 1 bit: read/pop request, driven by the consuming controller.
REQ-008 SHALL have port o_rd_data, output, NB_DATA: head-of-queue word, first-word-fall-through.
REQ-009 SHALL have port o_empty, output, 1 bit: the queue holds 0 words.
REQ-010 SHALL have port o_full, output, 1 bit: the queue holds 2**NB_ADDR words.
REQ-011 SHALL have port o_count, output, NB_ADDR+1: current occupancy, 0..2**NB_ADDR.
REQ-012 SHALL have port o_overflow, output, 1 bit: sticky flag, a write was dropped.
REQ-013 SHALL have port o_underflow, output, 1 bit: sticky flag, a read was ignored.
REQ-014 SHALL have port i_clr_err, input, 1 bit: synchronous clear of both sticky flags.

Function
REQ-015 SHALL implement a circular buffer: write pointer, read pointer, occupancy counter, storage array.
REQ-016 SHALL drive o_rd_data combinationally from mem[rd_ptr]; it is valid whenever o_empty=0, so the consumer samples it in the cycle it asserts i_rd.
REQ-017 SHALL accept a write when i_wr=1 and not full: mem[wr_ptr] <= i_wr_data, wr_ptr+1; flags/count update the next cycle.
REQ-018 SHALL perform a pop when i_rd=1 and not empty: rd_ptr+1; the next word appears on o_rd_data the next cycle.
REQ-019 SHALL wrap both pointers modulo 2**NB_ADDR with no extra logic.
REQ-020 SHALL, on i_wr=1 with empty, ignore a simultaneous i_rd and set o_underflow; the word is written and becomes visible the next cycle.
REQ-021 SHALL, on i_wr=1 and i_rd=1 with full, perform both operations; count stays 2**NB_ADDR and overflow is not set.
REQ-022 SHALL, on i_wr=1 and i_rd=1 with neither empty nor full, perform both; count is unchanged.
REQ-023 SHALL, on i_wr=1 with full and no read, drop the word, leave memory and pointers untouched, and set o_overflow.
REQ-024 SHALL, on i_rd=1 with empty and no write, leave state unchanged and set o_underflow.
REQ-025 SHALL give i_clr_err priority over a same-cycle set; both flags read 0 the next cycle.
REQ-026 SHALL derive o_empty and o_full from registered state (count == 0 / count == depth), never from an input.

Reset
REQ-027 SHALL, on i_rst_n=0 and independent of clk, set wr_ptr=0, rd_ptr=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_underflow=0.
REQ-028 SHALL leave storage contents unreset; o_rd_data is don't-care while o_empty=1.
REQ-029 SHALL abandon any in-flight write/read on reset assertion mid-operation; the first post-release cycle shows empty.

Structure
REQ-030 SHALL place NB_DATA and NB_ADDR defaults in the shared UART/ALU package used by the UART, FIFO and interface blocks.
REQ-031 SHALL be a single module with storage inferred inline; no sub-module is needed; the same module is instantiated for the Tx path.

Verification
REQ-032 Reset then write 0xA5,0x11,0x22 over 3 cycles -> o_count=3, o_empty=0, o_rd_data=0xA5; three pops return 0xA5,0x11,0x22, then o_empty=1.
REQ-033 Write 16 words 0x00..0x0F, then a 17th 0xFF -> o_full=1, o_overflow=1; pops return 0x00..0x0F and 0xFF never appears.
REQ-034 Fill to 16, then i_wr=i_rd=1 with 0x40 -> count stays 16, pop yields 0x00, 0x40 is the last word read.
REQ-035 Empty, i_wr=i_rd=1 with 0x5A -> count=1, o_underflow=1, o_rd_data=0x5A next cycle; i_clr_err -> flags 0.
REQ-036 Push/pop 40 words through steady-state depth 3 -> pointer wrap is seamless, data order preserved, no flags set.
REQ-037 Assert i_rst_n=0 mid-clock with count=5 -> outputs reach reset values without a clock edge; after release o_empty=1.
